branch_resolve_update: RTL and testbench

- EX-stage branch resolution and predictor-update writer for the gshare pipeline; the write-side counterpart of the fetch-stage BTB/PHT lookup.
- Compares each resolved control-transfer's actual next PC against the next PC fetched after it; raises flush and redirect on mismatch.
- Maintains the speculative global history register (GHR), with restore on mispredict.
- Issues registered one-cycle write pulses to the PHT and BTB tables, and keeps saturating branch/mispredict statistics.

---
 rtl/bp_pkg.sv | 19 +
 rtl/sat_counter2.sv | 20 ++
 rtl/branch_resolve_update.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_update.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared gshare predictor constants and 2-bit counter encodings,
// used by both the fetch-side lookup and the EX-side update path.
package bp_pkg;

   localparam int ENTRY_BIT = 5;
   localparam int TAG_BIT   = 32 - ENTRY_BIT - 2;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   function automatic logic ctr_taken(input logic [1:0] ctr);
      return ctr >= WT;
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational saturating increment/decrement of a 2-bit PHT counter;
// zero latency, no flow control.
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] ctr_in,
   input  logic       taken,
   output logic [1:0] ctr_out
);

   always_comb begin
      ctr_out = ctr_in;
      if (taken && (ctr_in != ST)) begin
         ctr_out = ctr_in + 2'd1;
      end else if (!taken && (ctr_in != SNT)) begin
         ctr_out = ctr_in - 2'd1;
      end
   end

endmodule

// File: rtl/branch_resolve_update.sv
// EX-stage branch resolution: combinational flush/redirect, speculative GHR,
// and registered 1-cycle PHT/BTB write pulses; stall freezes all state.
module branch_resolve_update #(
   parameter  int ENTRY_BIT = bp_pkg::ENTRY_BIT,
   localparam int TAG_BIT   = 32 - ENTRY_BIT - 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 stall,
   input  logic                 ex_valid,
   input  logic                 ex_is_branch,
   input  logic                 ex_is_jal,
   input  logic                 ex_is_jalr,
   input  logic [31:0]          ex_pc,
   input  logic [31:0]          ex_pc_plus_imm,
   input  logic [31:0]          ex_alu_result,
   input  logic                 ex_bcond,
   input  logic [31:0]          ex_pred_next_pc,
   input  logic [1:0]           ex_pht_counter,
   input  logic [ENTRY_BIT-1:0] ex_ghr_snapshot,
   input  logic                 if_pred_valid,
   input  logic                 if_pred_taken,
   output logic                 is_flush,
   output logic [31:0]          redirect_pc,
   output logic [ENTRY_BIT-1:0] spec_ghr,
   output logic                 pht_we,
   output logic [ENTRY_BIT-1:0] pht_widx,
   output logic [1:0]           pht_wdata,
   output logic                 btb_we,
   output logic [ENTRY_BIT-1:0] btb_widx,
   output logic [TAG_BIT-1:0]   btb_wtag,
   output logic [31:0]          btb_wtarget,
   output logic                 btb_wis_branch,
   output logic [31:0]          branch_count,
   output logic [31:0]          mispredict_count
);

   logic                 resolve;
   logic [31:0]          actual_next;
   logic [1:0]           ctr_next;

   logic [ENTRY_BIT-1:0] ghr_d, ghr_q;
   logic                 pht_we_d, pht_we_q;
   logic [ENTRY_BIT-1:0] pht_widx_d, pht_widx_q;
   logic [1:0]           pht_wdata_d, pht_wdata_q;
   logic                 btb_we_d, btb_we_q;
   logic [ENTRY_BIT-1:0] btb_widx_d, btb_widx_q;
   logic [TAG_BIT-1:0]   btb_wtag_d, btb_wtag_q;
   logic [31:0]          btb_wtarget_d, btb_wtarget_q;
   logic                 btb_wis_branch_d, btb_wis_branch_q;
   logic [31:0]          branch_count_d, branch_count_q;
   logic [31:0]          mispredict_count_d, mispredict_count_q;

   assign resolve = ex_valid && !stall && (ex_is_branch || ex_is_jal || ex_is_jalr);

   always_comb begin
      actual_next = ex_pc_plus_imm;
      if (ex_is_jalr) begin
         actual_next = ex_alu_result & ~32'h1;
      end else if (ex_is_branch && !ex_bcond) begin
         actual_next = ex_pc + 32'd4;
      end
   end

   assign is_flush    = resolve && (actual_next != ex_pred_next_pc);
   assign redirect_pc = is_flush ? actual_next : 32'h0;

   sat_counter2 u_pht_ctr (
      .ctr_in  (ex_pht_counter),
      .taken   (ex_bcond),
      .ctr_out (ctr_next)
   );

   // A flush restores from the fetch-time snapshot and overrides any same-cycle fetch shift.
   always_comb begin
      ghr_d = ghr_q;
      if (is_flush && ex_is_branch) begin
         ghr_d = {ex_ghr_snapshot[ENTRY_BIT-2:0], ex_bcond};
      end else if (is_flush) begin
         ghr_d = ex_ghr_snapshot;
      end else if (if_pred_valid && !stall) begin
         ghr_d = {ghr_q[ENTRY_BIT-2:0], if_pred_taken};
      end
   end

   always_comb begin
      pht_we_d           = resolve && ex_is_branch;
      pht_widx_d         = ex_pc[ENTRY_BIT+1:2] ^ ex_ghr_snapshot;
      pht_wdata_d        = ctr_next;
      btb_we_d           = resolve;
      btb_widx_d         = ex_pc[ENTRY_BIT+1:2];
      btb_wtag_d         = ex_pc[31:ENTRY_BIT+2];
      btb_wtarget_d      = ex_is_jalr ? actual_next : ex_pc_plus_imm;
      btb_wis_branch_d   = ex_is_branch;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (resolve && (branch_count_q != 32'hFFFF_FFFF)) begin
         branch_count_d = branch_count_q + 32'd1;
      end
      if (is_flush && (mispredict_count_q != 32'hFFFF_FFFF)) begin
         mispredict_count_d = mispredict_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ghr_q              <= '0;
         pht_we_q           <= 1'b0;
         pht_widx_q         <= '0;
         pht_wdata_q        <= 2'b00;
         btb_we_q           <= 1'b0;
         btb_widx_q         <= '0;
         btb_wtag_q         <= '0;
         btb_wtarget_q      <= 32'h0;
         btb_wis_branch_q   <= 1'b0;
         branch_count_q     <= 32'h0;
         mispredict_count_q <= 32'h0;
      end else begin
         ghr_q              <= ghr_d;
         pht_we_q           <= pht_we_d;
         pht_widx_q         <= pht_widx_d;
         pht_wdata_q        <= pht_wdata_d;
         btb_we_q           <= btb_we_d;
         btb_widx_q         <= btb_widx_d;
         btb_wtag_q         <= btb_wtag_d;
         btb_wtarget_q      <= btb_wtarget_d;
         btb_wis_branch_q   <= btb_wis_branch_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign spec_ghr         = ghr_q;
   assign pht_we           = pht_we_q;
   assign pht_widx         = pht_widx_q;
   assign pht_wdata        = pht_wdata_q;
   assign btb_we           = btb_we_q;
   assign btb_widx         = btb_widx_q;
   assign btb_wtag         = btb_wtag_q;
   assign btb_wtarget      = btb_wtarget_q;
   assign btb_wis_branch   = btb_wis_branch_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_update.sv
// Directed-vector bench for branch_resolve_update; expected write pulses are
// queued at issue and checked by an independent monitor when they appear.
module tb_branch_resolve_update;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jal;
   logic        ex_is_jalr;
   logic [31:0] ex_pc;
   logic [31:0] ex_pc_plus_imm;
   logic [31:0] ex_alu_result;
   logic        ex_bcond;
   logic [31:0] ex_pred_next_pc;
   logic [1:0]  ex_pht_counter;
   logic [4:0]  ex_ghr_snapshot;
   logic        if_pred_valid;
   logic        if_pred_taken;
   logic        is_flush;
   logic [31:0] redirect_pc;
   logic [4:0]  spec_ghr;
   logic        pht_we;
   logic [4:0]  pht_widx;
   logic [1:0]  pht_wdata;
   logic        btb_we;
   logic [4:0]  btb_widx;
   logic [24:0] btb_wtag;
   logic [31:0] btb_wtarget;
   logic        btb_wis_branch;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   branch_resolve_update dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .stall            (stall),
      .ex_valid         (ex_valid),
      .ex_is_branch     (ex_is_branch),
      .ex_is_jal        (ex_is_jal),
      .ex_is_jalr       (ex_is_jalr),
      .ex_pc            (ex_pc),
      .ex_pc_plus_imm   (ex_pc_plus_imm),
      .ex_alu_result    (ex_alu_result),
      .ex_bcond         (ex_bcond),
      .ex_pred_next_pc  (ex_pred_next_pc),
      .ex_pht_counter   (ex_pht_counter),
      .ex_ghr_snapshot  (ex_ghr_snapshot),
      .if_pred_valid    (if_pred_valid),
      .if_pred_taken    (if_pred_taken),
      .is_flush         (is_flush),
      .redirect_pc      (redirect_pc),
      .spec_ghr         (spec_ghr),
      .pht_we           (pht_we),
      .pht_widx         (pht_widx),
      .pht_wdata        (pht_wdata),
      .btb_we           (btb_we),
      .btb_widx         (btb_widx),
      .btb_wtag         (btb_wtag),
      .btb_wtarget      (btb_wtarget),
      .btb_wis_branch   (btb_wis_branch),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   // kind: 0 none, 1 branch, 2 jal, 3 jalr. x_* fields are hand-computed expectations.
   typedef struct {
      logic [31:0] vld, kind, stall, pc, imm, alu, bcond, pred, ctr, snap, ifv, ift;
      logic [31:0] x_flush, x_redir, x_ghr;
      logic [31:0] x_wr, x_pwe, x_pidx, x_pdat, x_bidx, x_tag, x_tgt, x_isb, x_bc, x_mc;
   } vec_t;

   typedef struct {
      logic [31:0] pwe, pidx, pdat, bidx, tag, tgt, isb, bc, mc;
   } wr_t;

   wr_t         exp_q[$];
   logic [4:0]  exp_ghr;
   int          tests_run;
   int          tests_failed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk_idle(input logic [31:0] ghr);
      vec_t v;
      v = '{default: '0};
      v.x_ghr = ghr;
      return v;
   endfunction

   task automatic step(input vec_t v);
      wr_t w;
      @(posedge clk);
      #1;
      chk("spec_ghr", 32'(spec_ghr), 32'(exp_ghr));
      stall           = v.stall[0];
      ex_valid        = v.vld[0];
      ex_is_branch    = (v.kind == 32'd1);
      ex_is_jal       = (v.kind == 32'd2);
      ex_is_jalr      = (v.kind == 32'd3);
      ex_pc           = v.pc;
      ex_pc_plus_imm  = v.imm;
      ex_alu_result   = v.alu;
      ex_bcond        = v.bcond[0];
      ex_pred_next_pc = v.pred;
      ex_pht_counter  = v.ctr[1:0];
      ex_ghr_snapshot = v.snap[4:0];
      if_pred_valid   = v.ifv[0];
      if_pred_taken   = v.ift[0];
      if (v.x_wr != 32'd0) begin
         w = '{v.x_pwe, v.x_pidx, v.x_pdat, v.x_bidx, v.x_tag, v.x_tgt, v.x_isb, v.x_bc, v.x_mc};
         exp_q.push_back(w);
      end
      exp_ghr = v.x_ghr[4:0];
      @(negedge clk);
      chk("is_flush", 32'(is_flush), v.x_flush);
      chk("redirect_pc", redirect_pc, v.x_redir);
   endtask

   // Monitor: every write pulse the DUT presents must match the oldest queued expectation.
   always @(negedge clk) begin
      wr_t w;
      if (reset_n && (pht_we || btb_we)) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_write: got pht_we=%0b btb_we=%0b expected no write at %0t",
                     pht_we, btb_we, $time);
         end else begin
            w = exp_q.pop_front();
            chk("pht_we", 32'(pht_we), w.pwe);
            if (w.pwe != 32'd0) begin
               chk("pht_widx", 32'(pht_widx), w.pidx);
               chk("pht_wdata", 32'(pht_wdata), w.pdat);
            end
            chk("btb_we", 32'(btb_we), 32'd1);
            chk("btb_widx", 32'(btb_widx), w.bidx);
            chk("btb_wtag", 32'(btb_wtag), w.tag);
            chk("btb_wtarget", btb_wtarget, w.tgt);
            chk("btb_wis_branch", 32'(btb_wis_branch), w.isb);
            chk("branch_count", branch_count, w.bc);
            chk("mispredict_count", mispredict_count, w.mc);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      tests_run       = 0;
      tests_failed    = 0;
      exp_ghr         = 5'd0;
      reset_n         = 1'b0;
      stall           = 1'b0;
      ex_valid        = 1'b0;
      ex_is_branch    = 1'b0;
      ex_is_jal       = 1'b0;
      ex_is_jalr      = 1'b0;
      ex_pc           = 32'h0;
      ex_pc_plus_imm  = 32'h0;
      ex_alu_result   = 32'h0;
      ex_bcond        = 1'b0;
      ex_pred_next_pc = 32'h0;
      ex_pht_counter  = 2'd0;
      ex_ghr_snapshot = 5'd0;
      if_pred_valid   = 1'b0;
      if_pred_taken   = 1'b0;

      #3;
      chk("rst_spec_ghr", 32'(spec_ghr), 32'd0);
      chk("rst_btb_we", 32'(btb_we), 32'd0);
      chk("rst_branch_count", branch_count, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Correct taken branch, with a same-cycle taken fetch prediction.
      v = '{1, 1, 0, 'h100, 'h140, 0, 1, 'h140, 2, 'b00011, 1, 1,
            0, 0, 'b00001,
            1, 1, 3, 3, 0, 2, 'h140, 1, 1, 0};
      step(v);
      step(mk_idle('b00001));

      // Async reset between edges while the write pulse and counters are live.
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_spec_ghr", 32'(spec_ghr), 32'd0);
      chk("arst_pht_we", 32'(pht_we), 32'd0);
      chk("arst_pht_wdata", 32'(pht_wdata), 32'd0);
      chk("arst_btb_we", 32'(btb_we), 32'd0);
      chk("arst_btb_wtarget", btb_wtarget, 32'd0);
      chk("arst_branch_count", branch_count, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_ghr = 5'd0;
      step(mk_idle(0));
      chk("post_rst_btb_we", 32'(btb_we), 32'd0);
      chk("post_rst_pht_we", 32'(pht_we), 32'd0);

      // Mispredicted not-taken branch; restore beats the same-cycle fetch shift.
      v = '{1, 1, 0, 'h104, 'h180, 0, 0, 'h200, 2, 'b10101, 1, 1,
            1, 'h108, 'b01010,
            1, 1, 'h14, 1, 1, 2, 'h180, 1, 1, 1};
      step(v);
      // jalr, bit 0 of the raw target cleared, predicted correctly.
      v = '{1, 3, 0, 'h300, 'h999, 'h2003, 0, 'h2002, 0, 0, 0, 0,
            0, 0, 'b01010,
            1, 0, 0, 0, 0, 6, 'h2002, 0, 2, 1};
      step(v);
      // Mispredicted jal restores the snapshot unshifted.
      v = '{1, 2, 0, 'h400, 'h480, 0, 0, 'h404, 0, 'b11100, 0, 0,
            1, 'h480, 'b11100,
            1, 0, 0, 0, 0, 8, 'h480, 0, 3, 2};
      step(v);
      // Fetch-only cycle shifts a not-taken prediction into the GHR.
      v = mk_idle('b11000);
      v.ifv = 1;
      step(v);
      // Counter saturation: ST taken stays ST, SNT not-taken stays SNT.
      v = '{1, 1, 0, 'h108, 'h1c0, 0, 1, 'h1c0, 3, 0, 0, 0,
            0, 0, 'b11000,
            1, 1, 2, 3, 2, 2, 'h1c0, 1, 4, 2};
      step(v);
      v = '{1, 1, 0, 'h10c, 'h50, 0, 0, 'h110, 0, 'b00001, 0, 0,
            0, 0, 'b11000,
            1, 1, 2, 0, 3, 2, 'h50, 1, 5, 2};
      step(v);
      // Mispredicted taken branch, weak-not-taken counter moves to weak-taken.
      v = '{1, 1, 0, 'h10c, 'h200, 0, 1, 'h110, 1, 'b00001, 0, 0,
            1, 'h200, 'b00011,
            1, 1, 2, 2, 3, 2, 'h200, 1, 6, 3};
      step(v);
      // Same mispredicting branch under stall: nothing may change.
      v = '{1, 1, 1, 'h10c, 'h200, 0, 1, 'h110, 1, 'b00001, 1, 1,
            0, 0, 'b00011,
            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      step(v);
      // Bubble carrying branch bits and a wrong prediction.
      v = '{0, 1, 0, 'h10c, 'h200, 0, 1, 'h110, 1, 'b00001, 0, 0,
            0, 0, 'b00011,
            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      step(v);
      // Valid non-control instruction with a taken fetch prediction.
      v = '{1, 0, 0, 'h500, 0, 0, 0, 'h999, 0, 0, 1, 1,
            0, 0, 'b00111,
            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      step(v);
      step(mk_idle('b00111));

      // Preload both statistics counters to all-ones, then resolve through them.
      force dut.branch_count_q     = 32'hFFFF_FFFF;
      force dut.mispredict_count_q = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.branch_count_q;
      release dut.mispredict_count_q;
      v = '{1, 1, 0, 'h104, 'h180, 0, 0, 'h200, 2, 'b10101, 0, 0,
            1, 'h108, 'b01010,
            1, 1, 'h14, 1, 1, 2, 'h180, 1, 'hFFFFFFFF, 'hFFFFFFFF};
      step(v);
      v = '{1, 1, 0, 'h100, 'h140, 0, 1, 'h140, 2, 'b00011, 0, 0,
            0, 0, 'b01010,
            1, 1, 3, 3, 0, 2, 'h140, 1, 'hFFFFFFFF, 'hFFFFFFFF};
      step(v);
      step(mk_idle('b01010));
      step(mk_idle('b01010));
      chk("write_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
